// File: rtl/alu_seq.sv
// Registered, handshaked ALU with status flags and an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to build the multi-cycle MUL path. Without it, opcode 6 returns zero in one cycle.
module alu_seq #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ALU_in_1,
  input  logic [N-1:0] ALU_in_2,
  input  logic [2:0]   ALU_control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALU_out,
  output logic         Zero_flag,
  output logic         Carry_flag,
  output logic         Overflow_flag,
  output logic         Neg_flag
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = 2 * N;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1
`ifdef ALU_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t state, state_nxt, accept_state;

  logic         accept;
  logic [N:0]   sum, diff;
  logic [CW-1:0] shamt;
  logic [N-1:0] res_c;
  logic         carry_c, ovf_c;

`ifdef ALU_MUL_EN
  logic [N-1:0]  a_q, b_q;
  logic [AW-1:0] acc, acc_nxt;
  logic [CW-1:0] count;
  logic          mul_last;
`endif

  assign accept    = in_valid && in_ready;
  assign Zero_flag = (ALU_out == '0);
  assign Neg_flag  = ALU_out[N-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state; an accepted op goes to HOLD unless it is a multiply
  always_comb begin
    state_nxt    = state;
    accept_state = S_HOLD;
`ifdef ALU_MUL_EN
    if (ALU_control == OP_MUL) accept_state = S_MUL;
`endif
    case (state)
      S_IDLE: if (accept) state_nxt = accept_state;
`ifdef ALU_MUL_EN
      S_MUL:  if (mul_last) state_nxt = S_HOLD;
`endif
      S_HOLD: if (out_ready) state_nxt = in_valid ? accept_state : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; HOLD can hand off and accept in the same cycle
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Single-cycle datapath
  always_comb begin
    sum     = {1'b0, ALU_in_1} + {1'b0, ALU_in_2};
    diff    = {1'b0, ALU_in_1} - {1'b0, ALU_in_2};
    shamt   = ALU_in_2[CW-1:0];
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (ALU_control)
      OP_ADD: begin
        res_c   = sum[N-1:0];
        carry_c = sum[N];
        ovf_c   = (ALU_in_1[N-1] == ALU_in_2[N-1]) && (sum[N-1] != ALU_in_1[N-1]);
      end
      OP_SUB: begin
        res_c   = diff[N-1:0];
        carry_c = diff[N];
        ovf_c   = (ALU_in_1[N-1] != ALU_in_2[N-1]) && (diff[N-1] != ALU_in_1[N-1]);
      end
      OP_AND: res_c = ALU_in_1 & ALU_in_2;
      OP_OR:  res_c = ALU_in_1 | ALU_in_2;
      OP_SLT: res_c = {{(N-1){1'b0}}, ($signed(ALU_in_1) < $signed(ALU_in_2))};
      OP_SHL: res_c = ALU_in_1 << shamt;
      OP_SHR: res_c = ALU_in_1 >> shamt;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  // One multiplier bit per cycle, LSB first
  always_comb begin
    mul_last = (count == CW'(N - 1));
    acc_nxt  = acc;
    if (b_q[count]) acc_nxt = acc + (AW'(a_q) << count);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      count <= '0;
    end else if (accept && accept_state == S_MUL) begin
      a_q   <= ALU_in_1;
      b_q   <= ALU_in_2;
      acc   <= '0;
      count <= '0;
    end else if (state == S_MUL) begin
      acc   <= acc_nxt;
      count <= count + CW'(1);
    end
  end
`endif

  // Result and flag registers stay frozen until the next result lands
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_out       <= '0;
      Carry_flag    <= 1'b0;
      Overflow_flag <= 1'b0;
    end else begin
`ifdef ALU_MUL_EN
      if (state == S_MUL) begin
        if (mul_last) begin
          ALU_out       <= acc_nxt[N-1:0];
          Carry_flag    <= |acc_nxt[AW-1:N];
          Overflow_flag <= 1'b0;
        end
      end else
`endif
      if (accept && accept_state == S_HOLD) begin
        ALU_out       <= res_c;
        Carry_flag    <= carry_c;
        Overflow_flag <= ovf_c;
      end
    end
  end

endmodule
